distortion_pipe: RTL and testbench
==================================

DISTORTION_PIPE -- requirements
Module: distortion_pipe

Interface
REQ-001 Parameters SHALL be: DW, default 16, sample width (signed); GW, default 16, gain width (signed); GFRAC, default 8, gain fractional bits; CW, default 16, clip-counter width.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  DW  signed input sample.
- in_ch  in  1  channel tag (0=L, 1=R), carried through.
- mode  in  2  00 bypass, 01 hard clip, 10 soft clip, 11 fold-back.
- threshold  in  DW-1  unsigned clip magnitude T.
- gain  in  GW  signed gain, Q format with GFRAC fraction bits.
- clr_cnt  in  1  synchronous clear of clip_cnt.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DW  signed processed sample.
- out_ch  out  1  channel tag of out_data.
- out_clip  out  1  sample was clipped, folded or saturated.
- clip_cnt  out  CW  saturating count of samples emitted with out_clip=1.

Function
REQ-003 The datapath SHALL be a 3-stage pipeline (S1 shape, S2 multiply, S3 shift/saturate) with one valid bit per stage.
REQ-004 advance = out_ready OR NOT out_valid; in_ready SHALL equal advance; all stages SHALL move together only when advance=1, otherwise hold.
REQ-005 A sample SHALL be accepted when in_valid AND in_ready; bubbles SHALL propagate as invalid stages, never collapsed.
REQ-006 Latency SHALL be exactly 3 cycles from acceptance to out_valid when unstalled; throughput 1 sample/cycle.
REQ-007 mode, threshold and gain SHALL be sampled into S1 at acceptance and travel with the sample; mid-stream changes SHALL affect only later-accepted samples.
REQ-008 S1, with x=in_data and T=threshold zero-extended: bypass passes x; hard clip gives +T if x>T, -T if x<-T, else x.
REQ-009 Soft clip SHALL give sign(x)*(T+((|x|-T)>>1)) when |x|>T, else x; |x| computed at DW+1 bits so -2^(DW-1) is exact.
REQ-010 Fold-back SHALL give sign(x)*(2T-|x|) when |x|>T, then clamp to [-T,+T]; else x.
REQ-011 S2 SHALL form the full-precision signed product S1*gain (DW+GW bits); bypass SHALL skip the multiply (gain ignored).
REQ-012 S3 SHALL arithmetic-shift right by GFRAC (floor) and saturate to [-2^(DW-1), 2^(DW-1)-1].
REQ-013 out_clip SHALL be 1 when S1 altered the sample or S3 saturated; always 0 in bypass.
REQ-014 out_ch SHALL equal the in_ch of the same sample; stereo ordering SHALL be preserved.
REQ-015 clip_cnt SHALL increment on each out_valid AND out_ready AND out_clip handshake, saturating at 2^CW-1.
REQ-016 clr_cnt SHALL zero clip_cnt, taking priority over a simultaneous increment.
REQ-017 out_data, out_ch, out_clip SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-018 rst_n=0 SHALL immediately clear all stage valids, out_valid, out_data, out_ch, out_clip and clip_cnt to 0, regardless of clk.
REQ-019 During reset in_ready SHALL read 1 (advance=1 as out_valid=0); samples in flight SHALL be discarded with no partial output after release.
REQ-020 After rst_n rises, the first accepted sample SHALL appear 3 cycles later.

Verification
REQ-021 Reset: assert rst_n=0 mid-stream with 3 samples in flight -> out_valid=0, clip_cnt=0 same cycle; no stale sample after release.
REQ-022 Hard clip, T=1000, gain=0x0100: in 5000, -5000, 700 -> out 1000, -1000, 700; out_clip 1,1,0; clip_cnt=2.
REQ-023 Soft clip, T=1000, gain=0x0100: in 3000 -> 2000; -32768 -> -16884; gain=0x0200, in 500 -> 1000, out_clip=0.
REQ-024 Fold-back, T=1000: in 1500 -> 500; -1500 -> -500; 4000 -> -1000 (clamped); out_clip=1 each.
REQ-025 Saturation, hard clip T=20000, gain=0x0400: in 20000 -> 32767; -20000 -> -32768; out_clip=1; bypass with same inputs -> unchanged, out_clip=0.
REQ-026 Backpressure: stream 6 samples alternating in_ch, out_ready low 5 cycles -> in_ready low while out_valid held, outputs stable, all 6 delivered in order with correct out_ch; params changed mid-stall apply only to later samples.

Source files
------------

// File: rtl/distortion_pipe.sv
// rtl/distortion_pipe.sv - three-stage stereo distortion pipeline (shape, gain multiply, shift/saturate)
module distortion_pipe #(
    parameter int DW    = 16,
    parameter int GW    = 16,
    parameter int GFRAC = 8,
    parameter int CW    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_ch,
    input  logic [1:0]           mode,
    input  logic [DW-2:0]        threshold,
    input  logic signed [GW-1:0] gain,
    input  logic                 clr_cnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_ch,
    output logic                 out_clip,
    output logic [CW-1:0]        clip_cnt
);

    localparam int PW = DW + GW;
    localparam int EW = DW + 2;

    localparam logic signed [PW-1:0] MAXV = $signed({{(GW + 1){1'b0}}, {(DW - 1){1'b1}}});
    localparam logic signed [PW-1:0] MINV = $signed({{(GW + 1){1'b1}}, {(DW - 1){1'b0}}});

    logic advance;
    logic accept;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;
    assign accept   = in_valid & in_ready;

    // S1 shaping is done at DW+2 bits so |x| of the most negative sample and 2T stay exact
    logic signed [EW-1:0] x_e;
    logic signed [EW-1:0] t_e;
    logic signed [EW-1:0] ax;
    logic signed [EW-1:0] mag;
    logic signed [EW-1:0] shaped;
    logic                 x_neg;
    logic                 over;
    logic                 alt;
    logic signed [DW-1:0] shaped_s;

    always_comb begin
        x_e    = $signed({{2{in_data[DW-1]}}, in_data});
        t_e    = $signed({3'b000, threshold});
        x_neg  = in_data[DW-1];
        ax     = x_neg ? -x_e : x_e;
        over   = (ax > t_e);
        mag    = t_e;
        shaped = x_e;
        alt    = 1'b0;
        case (mode)
            2'b10: mag = t_e + ((ax - t_e) >>> 1);
            2'b11: begin
                mag = (t_e <<< 1) - ax;
                if (mag < -t_e) begin
                    mag = -t_e;
                end
            end
            default: mag = t_e;
        endcase
        if ((mode != 2'b00) && over) begin
            alt    = 1'b1;
            shaped = x_neg ? -mag : mag;
        end
        shaped_s = shaped[DW-1:0];
    end

    logic                 s1_valid;
    logic signed [DW-1:0] s1_data;
    logic signed [GW-1:0] s1_gain;
    logic                 s1_byp;
    logic                 s1_alt;
    logic                 s1_ch;

    logic                 s2_valid;
    logic signed [PW-1:0] s2_prod;
    logic                 s2_alt;
    logic                 s2_ch;

    // Bypass pre-scales by 2^GFRAC so the S3 shift returns the sample untouched
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] prod;

    always_comb begin
        d_ext = $signed({{GW{s1_data[DW-1]}}, s1_data});
        g_ext = $signed({{DW{s1_gain[GW-1]}}, s1_gain});
        if (s1_byp) begin
            prod = d_ext <<< GFRAC;
        end else begin
            prod = d_ext * g_ext;
        end
    end

    logic signed [PW-1:0] shifted;
    logic signed [DW-1:0] sat_data;
    logic                 sat;

    always_comb begin
        shifted  = s2_prod >>> GFRAC;
        sat      = 1'b0;
        sat_data = shifted[DW-1:0];
        if (shifted > MAXV) begin
            sat      = 1'b1;
            sat_data = MAXV[DW-1:0];
        end else if (shifted < MINV) begin
            sat      = 1'b1;
            sat_data = MINV[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_gain   <= '0;
            s1_byp    <= 1'b0;
            s1_alt    <= 1'b0;
            s1_ch     <= 1'b0;
            s2_valid  <= 1'b0;
            s2_prod   <= '0;
            s2_alt    <= 1'b0;
            s2_ch     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 1'b0;
            out_clip  <= 1'b0;
        end else if (advance) begin
            s1_valid  <= accept;
            s1_data   <= shaped_s;
            s1_gain   <= gain;
            s1_byp    <= (mode == 2'b00);
            s1_alt    <= alt;
            s1_ch     <= in_ch;
            s2_valid  <= s1_valid;
            s2_prod   <= prod;
            s2_alt    <= s1_alt;
            s2_ch     <= s1_ch;
            out_valid <= s2_valid;
            out_data  <= sat_data;
            out_ch    <= s2_ch;
            out_clip  <= s2_alt | sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= '0;
        end else if (clr_cnt) begin
            clip_cnt <= '0;
        end else if (out_valid && out_ready && out_clip && (clip_cnt != {CW{1'b1}})) begin
            clip_cnt <= clip_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_distortion_pipe.sv
// tb/tb_distortion_pipe.sv - self-checking bench for distortion_pipe
module tb_distortion_pipe;

    localparam int DW    = 16;
    localparam int GW    = 16;
    localparam int GFRAC = 8;
    localparam int CW    = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_ch = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic [DW-2:0]        threshold = '0;
    logic signed [GW-1:0] gain = 16'sh0100;
    logic                 clr_cnt = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_data;
    logic                 out_ch;
    logic                 out_clip;
    logic [CW-1:0]        clip_cnt;

    distortion_pipe #(.DW(DW), .GW(GW), .GFRAC(GFRAC), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .mode(mode), .threshold(threshold), .gain(gain), .clr_cnt(clr_cnt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_clip(out_clip), .clip_cnt(clip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit ch;
        bit clip;
    } exp_t;

    exp_t q[$];
    int   vecs = 0;
    int   errs = 0;
    int   exp_cnt = 0;
    bit   use_dir = 1'b0;
    int   dir_data = 0;
    bit   dir_clip = 1'b0;
    bit   last_acc = 1'b0;

    task automatic chk(input string tag, input longint obs, input longint expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input int x, input bit ch, input int md, input int t, input int g);
        exp_t   e;
        int     ax, m, y;
        longint p, s;
        bit     alt;
        alt = 1'b0;
        ax  = (x < 0) ? -x : x;
        y   = x;
        if (md != 0 && ax > t) begin
            alt = 1'b1;
            case (md)
                1: m = t;
                2: m = t + (ax - t) / 2;
                default: begin
                    m = 2 * t - ax;
                    if (m < -t) m = -t;
                end
            endcase
            y = (x < 0) ? -m : m;
        end
        if (md == 0) begin
            s = y;
        end else begin
            p = longint'(y) * longint'(g);
            s = p / 256;
            if (p < 0 && (p % 256) != 0) s = s - 1;
        end
        if (s > 32767) begin
            s = 32767; alt = 1'b1;
        end else if (s < -32768) begin
            s = -32768; alt = 1'b1;
        end
        e.data = int'(s);
        e.ch   = ch;
        e.clip = alt;
        return e;
    endfunction

    task automatic cyc();
        bit   hs_clip;
        exp_t e;
        #1;
        hs_clip = 1'b0;
        chk("clip_cnt", clip_cnt, exp_cnt);
        chk("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("stray_valid", out_valid, 0);
            end else begin
                chk("out_data", out_data, q[0].data);
                chk("out_ch", out_ch, q[0].ch);
                chk("out_clip", out_clip, q[0].clip);
                if (out_ready) begin
                    hs_clip = q[0].clip;
                    void'(q.pop_front());
                end
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            if (use_dir) begin
                e.data = dir_data; e.ch = in_ch; e.clip = dir_clip;
            end else begin
                e = model(int'(in_data), in_ch, int'(mode), int'(threshold), int'(gain));
            end
            q.push_back(e);
        end
        @(posedge clk);
        if (clr_cnt) exp_cnt = 0;
        else if (hs_clip && exp_cnt < 65535) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic send(input int x, input bit ch, input int ed, input bit ec);
        in_valid = 1'b1; in_data = x[DW-1:0]; in_ch = ch;
        use_dir = 1'b1; dir_data = ed; dir_clip = ec;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (last_acc) break;
        end
        chk("send_accepted", last_acc, 1);
        in_valid = 1'b0; use_dir = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
        chk("drained", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[6];
        int n;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_clip_cnt", clip_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Hard clip; first sample also measures the 3-cycle latency
        mode = 2'b01; threshold = 15'd1000; gain = 16'sh0100;
        in_valid = 1'b1; in_data = 16'sd5000; in_ch = 1'b0;
        use_dir = 1'b1; dir_data = 1000; dir_clip = 1'b1;
        cyc();
        chk("lat_acc", last_acc, 1);
        in_valid = 1'b0; use_dir = 1'b0;
        chk("lat_c1", out_valid, 0);
        cyc();
        chk("lat_c2", out_valid, 0);
        cyc();
        chk("lat_c3", out_valid, 1);
        send(-5000, 1'b1, -1000, 1'b1);
        send(700, 1'b0, 700, 1'b0);
        drain();
        chk("hard_cnt", clip_cnt, 2);
        clr_cnt = 1'b1; cyc(); clr_cnt = 1'b0;
        chk("clr_cnt", clip_cnt, 0);

        mode = 2'b10;
        send(3000, 1'b0, 2000, 1'b1);
        send(-32768, 1'b1, -16884, 1'b1);
        gain = 16'sh0200;
        send(500, 1'b0, 1000, 1'b0);
        drain();

        mode = 2'b11; gain = 16'sh0100;
        send(1500, 1'b0, 500, 1'b1);
        send(-1500, 1'b1, -500, 1'b1);
        send(4000, 1'b0, -1000, 1'b1);
        drain();

        mode = 2'b01; threshold = 15'd20000; gain = 16'sh0400;
        send(20000, 1'b0, 32767, 1'b1);
        send(-20000, 1'b1, -32768, 1'b1);
        mode = 2'b00;
        send(20000, 1'b0, 20000, 1'b0);
        send(-20000, 1'b1, -20000, 1'b0);
        drain();

        // Backpressure with a parameter change inside the stall window
        mode = 2'b01; threshold = 15'd1000; gain = 16'sh0100;
        for (int i = 0; i < 6; i++) vals[i] = int'($urandom_range(0, 8000)) - 4000;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            out_ready = !(c >= 4 && c < 9);
            if (c == 6) begin mode = 2'b10; gain = 16'sh0200; end
            in_valid = 1'b1; in_data = vals[n][DW-1:0]; in_ch = n[0];
            cyc();
            if (last_acc) n++;
        end
        chk("bp_sent", n, 6);
        drain();

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_ch     = $urandom;
            mode      = $urandom;
            threshold = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4000) : $urandom;
            gain      = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1024) : $urandom;
            clr_cnt   = ($urandom_range(0, 60) == 0);
            cyc();
        end
        clr_cnt = 1'b0;
        drain();

        // Reset with three samples in flight
        mode = 2'b01; threshold = 15'd100; gain = 16'sh0100; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'sd5000; in_ch = i[0];
            cyc();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_cnt", clip_cnt, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_data", out_data, 0);
        q.delete();
        exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        send(-300, 1'b1, -100, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
